// File: rtl/nes_joy_pkg.sv
// Shared definitions for the NES joypad serializer: button bit positions
// within the 12-bit controller word and the NES shift-register length.
package nes_joy_pkg;

    // Bit positions in a 12-bit button word (bits 7:0 follow NES read order)
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_TA     = 8;
    localparam int BTN_TB     = 9;

    // Number of bits the NES reads from one 4021 shift register
    localparam int NES_BITS = 8;

    // Merged button word coming from the controller front-ends
    typedef logic [11:0] joy_btns_t;

endpackage

// File: rtl/joy_turbo_gen.sv
// Turbo (autofire) generator for one joypad port.
// While either turbo button is held, a square wave with half-period
// HP = FREQ/(2*AUTOFIRE_HZ) clk cycles gates the A/B turbo outputs.
// The wave starts in its active phase on the cycle after the press so
// that a tap always fires at least once.
module joy_turbo_gen #(
    parameter int FREQ        = 21_492_000,
    parameter int AUTOFIRE_HZ = 15
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn_a,
    input  logic btn_b,
    output logic turbo_a,
    output logic turbo_b
);

    localparam int HP    = FREQ / (2 * AUTOFIRE_HZ);
    localparam int CNT_W = (HP > 1) ? $clog2(HP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HP - 1);

    // A half-period below two cycles cannot produce a usable square wave
    if (HP < 2) begin : g_hp_too_small
        $error("joy_turbo_gen: FREQ/(2*AUTOFIRE_HZ) must be at least 2");
    end

    logic             w_held;
    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;
    logic             r_held;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_phase_nxt;

    assign w_held = btn_a | btn_b;

    // Next counter/phase: idle when released, fire at once on a new press,
    // otherwise count out the half-period and toggle the phase on wrap
    always_comb begin
        w_cnt_nxt   = '0;
        w_phase_nxt = 1'b0;
        if (!w_held) begin
            w_cnt_nxt   = '0;
            w_phase_nxt = 1'b0;
        end else if (!r_held) begin
            w_cnt_nxt   = '0;
            w_phase_nxt = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_phase_nxt = ~r_phase;
        end else begin
            w_cnt_nxt   = r_cnt + 1'b1;
            w_phase_nxt = r_phase;
        end
    end

    // Counter, phase and previous-held registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_held  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_phase <= w_phase_nxt;
            r_held  <= w_held;
        end
    end

    // Gate with the live buttons so a release stops firing immediately
    assign turbo_a = btn_a & r_phase;
    assign turbo_b = btn_b & r_phase;

endmodule

// File: rtl/nes_joypad_serializer.sv
// Parallel-to-serial bridge between merged controller button words and the
// NES core's joypad data inputs. Each port models a 4021 shift register:
// it tracks the buttons while strobe is high and shifts one bit out per
// falling edge of that port's read clock. Turbo A/B, opposite-direction
// D-pad lockout and a port swap are applied before the load.
module nes_joypad_serializer
    import nes_joy_pkg::*;
#(
    parameter int FREQ         = 21_492_000,
    parameter int AUTOFIRE_HZ  = 15,
    parameter int DPAD_LOCKOUT = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  joy_btns_t  joy1,
    input  joy_btns_t  joy2,
    input  logic       swap,
    input  logic       strobe,
    input  logic [1:0] joy_clk,
    output logic       data1,
    output logic       data2
);

    // Clear both directions of an impossible UP+DOWN or LEFT+RIGHT pair
    function automatic logic [NES_BITS-1:0] f_lockout(input logic [NES_BITS-1:0] b);
        logic [NES_BITS-1:0] m;
        m = b;
        if (b[BTN_UP] && b[BTN_DOWN]) begin
            m[BTN_UP]   = 1'b0;
            m[BTN_DOWN] = 1'b0;
        end
        if (b[BTN_LEFT] && b[BTN_RIGHT]) begin
            m[BTN_LEFT]  = 1'b0;
            m[BTN_RIGHT] = 1'b0;
        end
        return m;
    endfunction

    joy_btns_t           w_src [2];
    logic [1:0]          w_turbo_a;
    logic [1:0]          w_turbo_b;
    logic [1:0]          w_fall;
    logic [NES_BITS-1:0] w_dpad [2];
    logic [NES_BITS-1:0] w_load [2];
    logic [1:0]          r_last_clk;
    logic [NES_BITS-1:0] r_sreg [2];
    logic                w_unused;

    // Port source selection; swap only matters when the value is captured
    assign w_src[0] = swap ? joy2 : joy1;
    assign w_src[1] = swap ? joy1 : joy2;

    // Bits 11:10 of the button words carry nothing for the NES
    assign w_unused = ^{w_src[0][11:10], w_src[1][11:10]};

    // One turbo generator per port, driven by the post-swap turbo buttons
    for (genvar p = 0; p < 2; p++) begin : g_port
        joy_turbo_gen #(
            .FREQ        (FREQ),
            .AUTOFIRE_HZ (AUTOFIRE_HZ)
        ) u_turbo (
            .clk     (clk),
            .resetn  (resetn),
            .btn_a   (w_src[p][BTN_TA]),
            .btn_b   (w_src[p][BTN_TB]),
            .turbo_a (w_turbo_a[p]),
            .turbo_b (w_turbo_b[p])
        );
    end

    // Build the parallel load value: lockout on the D-pad, turbo ORed into A/B
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_dpad[p] = (DPAD_LOCKOUT != 0) ? f_lockout(w_src[p][NES_BITS-1:0])
                                            : w_src[p][NES_BITS-1:0];
            w_load[p] = {w_dpad[p][BTN_RIGHT],
                         w_dpad[p][BTN_LEFT],
                         w_dpad[p][BTN_DOWN],
                         w_dpad[p][BTN_UP],
                         w_dpad[p][BTN_START],
                         w_dpad[p][BTN_SELECT],
                         w_dpad[p][BTN_B] | w_turbo_b[p],
                         w_dpad[p][BTN_A] | w_turbo_a[p]};
        end
    end

    // Remember the previous read-clock level for falling-edge detection
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last_clk <= 2'b00;
        end else begin
            r_last_clk <= joy_clk;
        end
    end

    assign w_fall = r_last_clk & ~joy_clk;

    // Shift registers: strobe loads (and overrides a coincident shift),
    // a falling read clock shifts toward bit 0 and fills with ones
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int p = 0; p < 2; p++) begin
                r_sreg[p] <= '1;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (strobe) begin
                    r_sreg[p] <= w_load[p];
                end else if (w_fall[p]) begin
                    r_sreg[p] <= {1'b1, r_sreg[p][NES_BITS-1:1]};
                end
            end
        end
    end

    assign data1 = r_sreg[0][0];
    assign data2 = r_sreg[1][0];

endmodule

// File: tb/tb_nes_joypad_serializer.sv
// Self-checking bench for nes_joypad_serializer. A behavioural model keeps,
// per port, the captured 8-bit word plus a read index, and derives turbo
// phase from the length of the current held run. Two DUT instances share
// the stimulus: one with D-pad lockout, one without.
module tb_nes_joypad_serializer;

    localparam int FREQ = 1000;
    localparam int AFHZ = 50;
    localparam int HP   = FREQ / (2 * AFHZ);

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic [11:0] joy1   = '0;
    logic [11:0] joy2   = '0;
    logic        swap   = 1'b0;
    logic        strobe = 1'b0;
    logic [1:0]  joy_clk = 2'b00;
    logic        d1_lk, d2_lk, d1_nl, d2_nl;
    logic        started = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] rv_d1, rv_d2, rv_n1, rv_n2;

    always #5 clk = ~clk;

    nes_joypad_serializer #(.FREQ(FREQ), .AUTOFIRE_HZ(AFHZ), .DPAD_LOCKOUT(1)) u_dut_lk (
        .clk(clk), .resetn(resetn), .joy1(joy1), .joy2(joy2), .swap(swap),
        .strobe(strobe), .joy_clk(joy_clk), .data1(d1_lk), .data2(d2_lk)
    );

    nes_joypad_serializer #(.FREQ(FREQ), .AUTOFIRE_HZ(AFHZ), .DPAD_LOCKOUT(0)) u_dut_nl (
        .clk(clk), .resetn(resetn), .joy1(joy1), .joy2(joy2), .swap(swap),
        .strobe(strobe), .joy_clk(joy_clk), .data1(d1_nl), .data2(d2_nl)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // index [inst][port]; inst 0 = lockout, inst 1 = no lockout
    logic [7:0]  m_bits [2][2];
    int          m_idx  [2][2];
    int          m_run  [2];
    logic [1:0]  m_last;
    logic [11:0] ms;
    logic [7:0]  mv;
    logic        mphase, mta, mtb, mfall;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 2; i++) begin
                for (int p = 0; p < 2; p++) begin
                    m_bits[i][p] = 8'hFF;
                    m_idx[i][p]  = 8;
                end
            end
            m_run[0] = 0;
            m_run[1] = 0;
            m_last   = 2'b00;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (swap) ms = (p == 0) ? joy2 : joy1;
                else      ms = (p == 0) ? joy1 : joy2;
                mphase = (m_run[p] > 0) && ((((m_run[p] - 1) / HP) % 2) == 0);
                mta    = ms[8] & mphase;
                mtb    = ms[9] & mphase;
                mfall  = m_last[p] & ~joy_clk[p];
                for (int i = 0; i < 2; i++) begin
                    mv = ms[7:0];
                    if (i == 0) begin
                        if (mv[4] && mv[5]) mv[5:4] = 2'b00;
                        if (mv[6] && mv[7]) mv[7:6] = 2'b00;
                    end
                    mv[0] = mv[0] | mta;
                    mv[1] = mv[1] | mtb;
                    if (strobe) begin
                        m_bits[i][p] = mv;
                        m_idx[i][p]  = 0;
                    end else if (mfall) begin
                        m_idx[i][p] = (m_idx[i][p] < 8) ? m_idx[i][p] + 1 : 8;
                    end
                end
                m_run[p] = (ms[8] | ms[9]) ? m_run[p] + 1 : 0;
            end
            m_last = joy_clk;
        end
    end

    function automatic logic exp_bit(input int i, input int p);
        logic [7:0] w;
        w = m_bits[i][p];
        return (m_idx[i][p] < 8) ? w[m_idx[i][p]] : 1'b1;
    endfunction

    // Compare every DUT output against the model mid-cycle
    always @(negedge clk) begin
        if (started) begin
            check("lk.data1", {31'b0, d1_lk}, {31'b0, exp_bit(0, 0)});
            check("lk.data2", {31'b0, d2_lk}, {31'b0, exp_bit(0, 1)});
            check("nl.data1", {31'b0, d1_nl}, {31'b0, exp_bit(1, 0)});
            check("nl.data2", {31'b0, d2_nl}, {31'b0, exp_bit(1, 1)});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_strobe();
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
    endtask

    // Sample outputs, then produce one falling edge on the selected ports
    task automatic read_seq(input int n, input logic [1:0] mask);
        rv_d1 = '0; rv_d2 = '0; rv_n1 = '0; rv_n2 = '0;
        for (int i = 0; i < n; i++) begin
            rv_d1[i] = d1_lk;
            rv_d2[i] = d2_lk;
            rv_n1[i] = d1_nl;
            rv_n2[i] = d2_nl;
            joy_clk = joy_clk | mask;
            tick(3);
            joy_clk = joy_clk & ~mask;
            tick(3);
        end
    endtask

    initial begin
        resetn = 1'b0;
        tick(3);
        check("reset.data1", {31'b0, d1_lk}, 32'd1);
        check("reset.data2", {31'b0, d2_lk}, 32'd1);
        resetn = 1'b1;
        started = 1'b1;
        tick(2);

        // Basic read of A+START on port 1; port 2 holds A and never shifts
        joy1 = 12'h009;
        joy2 = 12'h001;
        do_strobe();
        read_seq(10, 2'b01);
        check("basic.data1", {22'b0, rv_d1[9:0]}, 32'h309);
        check("basic.data2", {22'b0, rv_d2[9:0]}, 32'h3FF);

        // Swap: port 1 sees joy2 (B), port 2 sees joy1 (nothing)
        swap = 1'b1;
        joy1 = 12'h000;
        joy2 = 12'h002;
        do_strobe();
        swap = 1'b0;
        read_seq(8, 2'b01);
        check("swap.data1", {24'b0, rv_d1[7:0]}, 32'h02);
        read_seq(8, 2'b10);
        check("swap.data2", {24'b0, rv_d2[7:0]}, 32'h00);

        // Lockout: UP+DOWN masked only on the lockout instance
        joy1 = 12'h030;
        joy2 = 12'h0C0;
        do_strobe();
        read_seq(8, 2'b11);
        check("lockout.on.data1",  {24'b0, rv_d1[7:0]}, 32'h00);
        check("lockout.off.data1", {24'b0, rv_n1[7:0]}, 32'h30);
        check("lockout.on.data2",  {24'b0, rv_d2[7:0]}, 32'h00);
        check("lockout.off.data2", {24'b0, rv_n2[7:0]}, 32'hC0);

        // Turbo A held from cycle 0 with HP=10
        joy1 = 12'h000;
        joy2 = 12'h000;
        tick(2);
        joy1 = 12'h100;           // cycle 0
        tick(5);                  // cycle 5
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        check("turbo.cycle5", {31'b0, d1_lk}, 32'd1);
        tick(9);                  // cycle 15
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        check("turbo.cycle15", {31'b0, d1_lk}, 32'd0);
        tick(5);                  // cycle 21
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        check("turbo.cycle21", {31'b0, d1_lk}, 32'd1);
        joy1 = 12'h000;           // release with a load in the same cycle
        strobe = 1'b1;
        tick();
        check("turbo.release", {31'b0, d1_lk}, 32'd0);
        joy1 = 12'h100;           // re-press: phase was cleared, not yet active
        tick();
        check("turbo.repress0", {31'b0, d1_lk}, 32'd0);
        tick();
        strobe = 1'b0;
        check("turbo.repress1", {31'b0, d1_lk}, 32'd1);
        joy1 = 12'h000;
        tick(2);

        // Strobe coinciding with a falling edge: load wins
        joy1 = 12'h001;
        joy_clk = 2'b01;
        tick(2);
        strobe = 1'b1;
        joy_clk = 2'b00;
        tick();
        check("sim.load_wins", {31'b0, d1_lk}, 32'd1);
        joy_clk = 2'b01;
        tick(2);
        joy_clk = 2'b00;
        tick(2);
        check("sim.strobe_held", {31'b0, d1_lk}, 32'd1);
        strobe = 1'b0;
        tick();
        joy_clk = 2'b01;
        tick(2);
        check("sim.rising_noop", {31'b0, d1_lk}, 32'd1);
        joy_clk = 2'b00;
        tick();
        check("sim.next_bit", {31'b0, d1_lk}, 32'd0);

        // Async reset midway through a read
        joy1 = 12'h000;
        joy2 = 12'h000;
        do_strobe();
        for (int i = 0; i < 3; i++) begin
            joy_clk = 2'b01;
            tick(2);
            joy_clk = 2'b00;
            tick(2);
        end
        check("rst.before", {31'b0, d1_lk}, 32'd0);
        #1 resetn = 1'b0;
        #1;
        check("rst.async.data1", {31'b0, d1_lk}, 32'd1);
        check("rst.async.data2", {31'b0, d2_lk}, 32'd1);
        #2 resetn = 1'b1;
        tick();
        read_seq(8, 2'b11);
        check("rst.after.data1", {24'b0, rv_d1[7:0]}, 32'hFF);
        check("rst.after.data2", {24'b0, rv_d2[7:0]}, 32'hFF);

        // Randomized traffic checked cycle by cycle against the model
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) joy1 = 12'($urandom);
            if ($urandom_range(0, 39) == 0) joy2 = 12'($urandom);
            if ($urandom_range(0, 49) == 0) swap = 1'($urandom);
            strobe = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 2) == 0) joy_clk[0] = ~joy_clk[0];
            if ($urandom_range(0, 2) == 0) joy_clk[1] = ~joy_clk[1];
            tick();
            if (k == 1500) begin
                #1 resetn = 1'b0;
                #1 resetn = 1'b1;
            end
        end
        strobe = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nes_joypad_serializer.md
Name: nes_joypad_serializer

Overview:
- Parallel-to-serial stage between the controller front-ends (SNES pad, DS2, USB HID, BL616 HID, all ORed into 12-bit button words) and the NES core's joypad1/joypad2 data inputs.
- Emulates two NES 4021 shift registers: latches on the CPU strobe and shifts on falling edges of the per-port joypad clocks.
- Adds per-port turbo on A/B, opposite-direction D-pad lockout and a port swap.

Parameters:
- FREQ, 21_492_000: clk frequency in Hz.
- AUTOFIRE_HZ, 15: turbo fire rate in Hz. Half-period HP = FREQ/(2*AUTOFIRE_HZ) cycles, computed at elaboration; HP must be at least 2.
- DPAD_LOCKOUT, 1: 1 enables masking of UP+DOWN and LEFT+RIGHT.

Ports:
- clk  in  1  system clock (NES clk).
- resetn  in  1  reset; one clock; reset is asynchronous and active-low.
- joy1  in  12  port-1 buttons. Bits [7:0] in NES order: A, B, SELECT, START, UP, DOWN, LEFT, RIGHT. Bit 8 is turbo-A, bit 9 is turbo-B, bits 11:10 are ignored.
- joy2  in  12  port-2 buttons, same layout as joy1.
- swap  in  1  1 means port 1 is fed from joy2 and port 2 from joy1.
- strobe  in  1  joypad_out[0] from the NES core.
- joy_clk  in  2  per-port read clocks from the NES core; bit n belongs to port n+1.
- data1  out  1  serial bit to the NES for port 1.
- data2  out  1  serial bit to the NES for port 2.

Behaviour:
- Reset:
  - shift registers are 8'hFF, so data1 = data2 = 1;
  - last_clk = 2'b00;
  - turbo counters = 0 and turbo phases = 0.
- Source select, per port: src = swap ? other joy : own joy. swap is evaluated only at load time.
- Lockout (DPAD_LOCKOUT=1): if UP&DOWN are both set, both are cleared; LEFT&RIGHT are handled the same way. The masking is combinational on src before the load.
- Load value: {src[7:2], src[1] | turbo_b, src[0] | turbo_a}.
- Load: on every clk edge where strobe=1, sreg is loaded with the load value. Holding strobe high keeps it tracking live buttons.
- Data output: dataN = sregN[0], driven straight from the flop. The new A value is visible in the cycle after the first strobe=1 sample.
- Falling-edge detection: a falling edge on port n is last_clk[n]=1 and joy_clk[n]=0. last_clk is updated every cycle.
- Shift: on a falling edge with strobe=0, sreg <= {1'b1, sreg[7:1]}. The new bit is visible in the next cycle.
- After 8 shifts the output reads 1 indefinitely until the next load. Further shifts are harmless.
- Strobe=1 coinciding with a falling edge: the load wins and no shift occurs.
- Falling edges on both ports in the same cycle are handled independently.
- Rising edges and a static clock level have no effect.
- Turbo generator, one per port, on the swapped source:
  - held = src[8] | src[9].
  - While held=0: counter=0 and phase=0.
  - On the first held cycle: phase <= 1 and counter <= 0, so turbo fires immediately.
  - While held: counter increments; at HP-1 it wraps to 0 and phase toggles.
  - turbo_a = src[8] & phase; turbo_b = src[9] & phase.
  - Counter width is $clog2(HP).
- Reset asserted mid-read: everything returns to reset values asynchronously. The first post-reset edge behaves like a fresh power-up.

Decomposition:
- Package nes_joy_pkg holds:
  - localparams for the bit indices (BTN_A=0 … BTN_RIGHT=7, BTN_TA=8, BTN_TB=9);
  - typedef joy_btns_t = logic [11:0];
  - the NES_BITS=8 constant.
- One sub-module, joy_turbo_gen (params FREQ, AUTOFIRE_HZ; ports clk, resetn, btn_a, btn_b, turbo_a, turbo_b), instantiated twice.
- The shift and lockout logic stays in the top of the block.

Test Plan:
- Basic read: joy1=12'h009 (A+START), strobe pulsed for 1 cycle, then 8 falling edges on joy_clk[0] spaced 6 cycles apart → data1 sequence 1,0,0,1,0,0,0,0, then 1 on the 9th and 10th reads. data2 stays 1 throughout.
- Swap: swap=1, joy2=12'h002 (B), joy1=0, strobe then reads on port 1 → data1 sequence 0,1,0,0,0,0,0,0. Port 2 reads all 0 for 8 bits.
- Lockout: joy1=12'h030 (UP+DOWN) → bits 4 and 5 read 0. With DPAD_LOCKOUT=0 both read 1.
- Turbo: FREQ=1000, AUTOFIRE_HZ=50 (HP=10), joy1[8] held from cycle 0 → phase is 1 for cycles 1–10, 0 for cycles 11–20, 1 from cycle 21. A strobe at cycle 5 gives data1=1; a strobe at cycle 15 gives data1=0. Releasing the button clears phase within 1 cycle.
- Simultaneous events: strobe=1 in the same cycle as a port-1 falling edge, with joy1=12'h001 → data1=1 (load wins, no shift). A falling edge with strobe held high changes nothing.
- Async reset: assert resetn=0 midway through a read (after 3 shifts), off a clock edge → data1 goes to 1 immediately. After release, 8 reads return 1 until a strobe.
